md_unit: RTL
============

MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and HI/LO width.
REQ-002 SHALL have parameter MULT_CYCLES, default 5, busy cycles for MULT/MULTU (range 1..31).
REQ-003 SHALL have parameter DIV_CYCLES, default 10, busy cycles for DIV/DIVU (range 1..31).
REQ-004 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port start  input  1  E-stage md instruction valid this cycle.
REQ-007 SHALL have port op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6-7 no-op.
REQ-008 SHALL have port a  input  WIDTH  rs operand (forwarded).
REQ-009 SHALL have port b  input  WIDTH  rt operand (forwarded).
REQ-010 SHALL have port md_use_d  input  1  D-stage instruction is any of mult/div/mfhi/mflo/mthi/mtlo.
REQ-011 SHALL have port busy  output  1  operation in progress.
REQ-012 SHALL have port hi  output  WIDTH  HI register.
REQ-013 SHALL have port lo  output  WIDTH  LO register.
REQ-014 SHALL have port stall_md  output  1  stall request to the stall controller (freeze PC/D, clear E).

Function
REQ-015 SHALL be a two-state FSM: IDLE, BUSY; 5-bit down-counter cnt.
REQ-016 IDLE, start=1, op in {0,1}: SHALL latch the operands, set cnt=MULT_CYCLES, go BUSY on that edge.
REQ-017 IDLE, start=1, op in {2,3}: SHALL latch the operands, set cnt=DIV_CYCLES, go BUSY on that edge.
REQ-018 IDLE, start=1, op=4: SHALL write hi<=a on that edge; op=5: SHALL write lo<=a; FSM stays IDLE.
REQ-019 start with op 6-7 SHALL be ignored.
REQ-020 BUSY: cnt SHALL decrement each edge.
REQ-021 BUSY with cnt==1: SHALL commit the result to hi/lo on that edge and return to IDLE.
REQ-022 busy SHALL be high for exactly N cycles (N = MULT_CYCLES or DIV_CYCLES), starting the cycle after start is sampled.
REQ-023 New hi/lo values SHALL be visible in the first cycle busy is low again.
REQ-024 start while BUSY SHALL be ignored; the stall protocol makes this unreachable, and assertions SHALL flag it.
REQ-025 MULT: {hi,lo} SHALL be the signed 2*WIDTH product.
REQ-026 MULTU: {hi,lo} SHALL be the unsigned 2*WIDTH product.
REQ-027 DIV: lo SHALL be the signed quotient truncated toward zero; hi SHALL be the remainder with the sign of the dividend.
REQ-028 DIVU: lo SHALL be the unsigned quotient; hi SHALL be the unsigned remainder.
REQ-029 DIV/DIVU with b==0 SHALL consume the full DIV_CYCLES busy time and leave hi/lo unchanged.
REQ-030 DIV of most-negative by -1 SHALL give lo=most-negative, hi=0.
REQ-031 Operands SHALL be held internally; changes on a/b during BUSY SHALL NOT affect the result.
REQ-032 stall_md SHALL be combinational: md_use_d & (busy | (start & op<=3)).
REQ-033 stall_md SHALL be low whenever md_use_d=0.

Reset
REQ-034 reset high SHALL immediately force hi=0, lo=0, busy=0, cnt=0, state IDLE, and stall_md=0 (asynchronous, independent of clk).
REQ-035 reset asserted mid-operation SHALL abort the operation; no commit SHALL occur after reset is released.
REQ-036 After reset deasserts, the first rising edge SHALL accept start normally.

Verification
REQ-037 MULT a=0xFFFFFFFE (-2), b=3 with defaults -> busy high for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-038 MULTU a=0xFFFFFFFF, b=2 -> hi=0x00000001, lo=0xFFFFFFFE after 5 busy cycles.
REQ-039 DIV a=-7 (0xFFFFFFF9), b=2 -> after 10 busy cycles lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIVU 7/0 with prior hi=0x11, lo=0x22 -> 10 busy cycles, hi/lo unchanged.
REQ-040 MTHI a=0x1234 -> hi=0x1234 next cycle, busy never asserts; MTLO likewise for lo.
REQ-041 start DIV with md_use_d=1 in the same cycle -> stall_md=1 that cycle and for all 10 busy cycles, 0 in the first idle cycle; with md_use_d=0 -> stall_md stays 0.
REQ-042 Assert reset in busy cycle 3 of a MULT -> hi=lo=0 and busy=0 immediately; no later write to hi/lo; a MTLO after release writes normally.

Source files
------------

// File: rtl/md_if.sv
// md_if: multiply/divide unit port bundle.
//   master (pipeline side): start, op, a, b, md_use_d  -> unit
//   slave  (md_unit side) : busy, hi, lo, stall_md     -> pipeline
interface md_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [2:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             md_use_d;
   logic             busy;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             stall_md;

   modport master (
      output start, op, a, b, md_use_d,
      input  busy, hi, lo, stall_md
   );

   modport slave (
      input  start, op, a, b, md_use_d,
      output busy, hi, lo, stall_md
   );
endinterface

// File: rtl/md_unit.sv
// md_unit: multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO registers.
//   clk, reset     : clock, asynchronous active-high reset
//   md.start/op    : E-stage md instruction valid and opcode
//                    (0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op)
//   md.a/md.b      : rs/rt operands, latched when an operation starts
//   md.md_use_d    : D-stage instruction touches the md unit
//   md.busy        : operation in progress
//   md.hi/md.lo    : HI/LO registers
//   md.stall_md    : stall request to the pipeline stall controller
//
// state  | meaning
// IDLE   | accepts start; MTHI/MTLO write directly
// BUSY   | counting down; result committed on the cnt==1 edge
module md_unit #(
   parameter int WIDTH       = 32,
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input logic clk,
   input logic reset,
   md_if.slave md
);

   typedef enum logic {S_IDLE, S_BUSY} state_t;

   state_t           state_q;
   logic [4:0]       cnt_q;
   logic [1:0]       op_q;     // bit1: divide, bit0: unsigned
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] hi_q;
   logic [WIDTH-1:0] lo_q;

   logic               sext_a;
   logic               sext_b;
   logic [2*WIDTH-1:0] prod;
   logic               div_signed;
   logic [WIDTH-1:0]   mag_a;
   logic [WIDTH-1:0]   mag_b;
   logic [WIDTH-1:0]   divisor;
   logic [WIDTH-1:0]   uq;
   logic [WIDTH-1:0]   ur;
   logic [WIDTH-1:0]   hi_d;
   logic [WIDTH-1:0]   lo_d;
   logic               commit_en;

   always_comb begin
      sext_a     = a_q[WIDTH-1] & ~op_q[0];
      sext_b     = b_q[WIDTH-1] & ~op_q[0];
      // Sign-extending to 2*WIDTH makes one unsigned multiply serve both flavours.
      prod       = {{WIDTH{sext_a}}, a_q} * {{WIDTH{sext_b}}, b_q};

      // Signed divide on magnitudes; the most-negative dividend's magnitude is
      // still exact as an unsigned value, so MIN / -1 wraps back to MIN.
      div_signed = ~op_q[0];
      mag_a      = (div_signed && a_q[WIDTH-1]) ? (~a_q + 1'b1) : a_q;
      mag_b      = (div_signed && b_q[WIDTH-1]) ? (~b_q + 1'b1) : b_q;
      divisor    = (b_q == '0) ? WIDTH'(1) : mag_b;
      uq         = mag_a / divisor;
      ur         = mag_a % divisor;

      if (op_q[1]) begin
         lo_d = (div_signed && (a_q[WIDTH-1] ^ b_q[WIDTH-1])) ? (~uq + 1'b1) : uq;
         hi_d = (div_signed && a_q[WIDTH-1]) ? (~ur + 1'b1) : ur;
      end else begin
         lo_d = prod[WIDTH-1:0];
         hi_d = prod[2*WIDTH-1:WIDTH];
      end

      // Divide by zero runs the full time but leaves HI/LO untouched.
      commit_en = ~(op_q[1] && (b_q == '0));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (md.start) begin
                  case (md.op)
                     3'd0, 3'd1, 3'd2, 3'd3: begin
                        op_q    <= md.op[1:0];
                        a_q     <= md.a;
                        b_q     <= md.b;
                        cnt_q   <= md.op[1] ? 5'(DIV_CYCLES) : 5'(MULT_CYCLES);
                        state_q <= S_BUSY;
                     end
                     3'd4:    hi_q <= md.a;
                     3'd5:    lo_q <= md.a;
                     default: ;
                  endcase
               end
            end
            S_BUSY: begin
               cnt_q <= cnt_q - 5'd1;
               if (cnt_q == 5'd1) begin
                  if (commit_en) begin
                     hi_q <= hi_d;
                     lo_q <= lo_d;
                  end
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign md.busy     = (state_q == S_BUSY);
   assign md.hi       = hi_q;
   assign md.lo       = lo_q;
   assign md.stall_md = ~reset & md.md_use_d &
                        ((state_q == S_BUSY) | (md.start & (md.op <= 3'd3)));

   // The stall controller must never let a new md instruction reach E while busy.
   a_no_start_busy: assert property (@(posedge clk) disable iff (reset)
                                     !(md.start && state_q == S_BUSY));

endmodule
